// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: receive FIFO sitting between the UART receiver and the
// register file. Supports 16550/16750-style FIFO mode with trigger levels and
// character timeout, a single holding register mode, sticky overrun, and a
// running count of stored entries that carry a line error.
// Head-of-queue data and all status flags come straight from registers; the
// next-cycle value of each is computed combinationally from the next state.

module uart_rx_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLEAR,
  input  logic          FIFOEN,
  input  logic [1:0]    RXTRIG,
  input  logic          WE,
  input  logic [7:0]    DIN,
  input  logic          PE_IN,
  input  logic          FE_IN,
  input  logic          BI_IN,
  input  logic          RD,
  input  logic          LSRRD,
  input  logic          CHAR_TICK,
  output logic [7:0]    DOUT,
  output logic          PE,
  output logic          FE,
  output logic          BI,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   USAGE,
  output logic          TRIGGER,
  output logic          TIMEOUT,
  output logic          OE,
  output logic          FIFOERR
);

  localparam logic [AW:0] L_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE     = (AW+1)'(1);
  localparam logic [AW:0] L_ZERO    = (AW+1)'(0);
  localparam logic [2:0]  L_TMO_MAX = 3'd4;

  // An entry carries a line error when any of its BI/FE/PE flags is set.
  function automatic logic entry_err(input logic [10:0] entry);
    return |entry[10:8];
  endfunction

  // Receive trigger level for the selected depth.
  function automatic logic [AW:0] trig_level(input logic [1:0] sel);
    logic [AW:0] lvl;
    lvl = L_ONE;
    if (DEPTH == 64) begin
      case (sel)
        2'b00:   lvl = (AW+1)'(1);
        2'b01:   lvl = (AW+1)'(16);
        2'b10:   lvl = (AW+1)'(32);
        2'b11:   lvl = (AW+1)'(56);
        default: lvl = (AW+1)'(1);
      endcase
    end else begin
      case (sel)
        2'b00:   lvl = (AW+1)'(1);
        2'b01:   lvl = (AW+1)'(4);
        2'b10:   lvl = (AW+1)'(8);
        2'b11:   lvl = (AW+1)'(14);
        default: lvl = (AW+1)'(1);
      endcase
    end
    return lvl;
  endfunction

  // Storage (not reset) and registered state
  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_usage;
  logic [AW:0]   r_err_cnt;
  logic [2:0]    r_tmo_cnt;
  logic          r_fifoen_q;
  logic [10:0]   r_head;
  logic          r_empty;
  logic          r_full;
  logic          r_trigger;
  logic          r_timeout;
  logic          r_oe;
  logic          r_fifoerr;

  // Combinational next-state
  logic          w_flush;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic          w_ovr;
  logic          w_overwrite;
  logic          w_mem_we;
  logic [AW-1:0] w_wr_slot;
  logic [10:0]   w_new_entry;
  logic          w_new_err;
  logic          w_head_err;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [AW:0]   w_usage_nxt;
  logic [AW:0]   w_err_cnt_nxt;
  logic [2:0]    w_tmo_nxt;
  logic [10:0]   w_head_nxt;
  logic          w_oe_nxt;
  logic          w_full_nxt;
  logic          w_trigger_nxt;

  // Decode accesses, flush and overrun, and compute every next-state value.
  always_comb begin
    w_new_entry   = {BI_IN, FE_IN, PE_IN, DIN};
    w_new_err     = entry_err(w_new_entry);
    w_head_err    = entry_err(r_head);
    // A mode change is treated exactly like a receive-FIFO reset.
    w_flush       = CLEAR | (FIFOEN != r_fifoen_q);
    w_rd_ok       = RD & ~r_empty & ~w_flush;
    // When full, a simultaneous read frees the slot the write needs.
    w_wr_ok       = WE & ~w_flush & (~r_full | RD);
    w_ovr         = WE & ~w_flush & r_full & ~RD;
    w_overwrite   = w_ovr & ~FIFOEN;
    w_mem_we      = w_wr_ok | w_overwrite;
    w_wr_slot     = w_overwrite ? r_rd_ptr : r_wr_ptr;

    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_usage_nxt   = r_usage;
    w_err_cnt_nxt = r_err_cnt;
    w_tmo_nxt     = r_tmo_cnt;
    w_head_nxt    = 11'd0;
    w_oe_nxt      = r_oe;

    if (w_flush) begin
      w_wr_ptr_nxt  = {AW{1'b0}};
      w_rd_ptr_nxt  = {AW{1'b0}};
      w_usage_nxt   = L_ZERO;
      w_err_cnt_nxt = L_ZERO;
    end else begin
      if (w_wr_ok) begin
        w_wr_ptr_nxt = r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_rd_ok) begin
        w_rd_ptr_nxt = r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   w_usage_nxt = r_usage + L_ONE;
        2'b01:   w_usage_nxt = r_usage - L_ONE;
        default: w_usage_nxt = r_usage;
      endcase
      if (w_overwrite) begin
        // Holding register replaced: the count is simply the new entry's state.
        w_err_cnt_nxt = {{AW{1'b0}}, w_new_err};
      end else begin
        case ({w_wr_ok & w_new_err, w_rd_ok & w_head_err})
          2'b10:   w_err_cnt_nxt = r_err_cnt + L_ONE;
          2'b01:   w_err_cnt_nxt = r_err_cnt - L_ONE;
          default: w_err_cnt_nxt = r_err_cnt;
        endcase
      end
    end

    // Next head: a write landing on the next read slot bypasses the array.
    if (w_usage_nxt == L_ZERO) begin
      w_head_nxt = 11'd0;
    end else if (w_mem_we && (w_wr_slot == w_rd_ptr_nxt)) begin
      w_head_nxt = w_new_entry;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end

    // Character timeout: any access or idle condition restarts it.
    if (w_flush || WE || RD || r_empty || !FIFOEN) begin
      w_tmo_nxt = 3'd0;
    end else if (CHAR_TICK && (r_tmo_cnt != L_TMO_MAX)) begin
      w_tmo_nxt = r_tmo_cnt + 3'd1;
    end else begin
      w_tmo_nxt = r_tmo_cnt;
    end

    // Overrun wins over a same-cycle LSR read so the event is never lost.
    if (w_ovr) begin
      w_oe_nxt = 1'b1;
    end else if (LSRRD) begin
      w_oe_nxt = 1'b0;
    end else begin
      w_oe_nxt = r_oe;
    end

    w_full_nxt    = (w_usage_nxt == (FIFOEN ? L_DEPTH : L_ONE));
    if (FIFOEN) begin
      w_trigger_nxt = (w_usage_nxt >= trig_level(RXTRIG));
    end else begin
      w_trigger_nxt = (w_usage_nxt != L_ZERO);
    end
  end

  // Entry storage write port; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_wr_slot] <= w_new_entry;
    end
  end

  // Pointers, counters, head register and status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_usage    <= L_ZERO;
      r_err_cnt  <= L_ZERO;
      r_tmo_cnt  <= 3'd0;
      r_fifoen_q <= 1'b0;
      r_head     <= 11'd0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_trigger  <= 1'b0;
      r_timeout  <= 1'b0;
      r_oe       <= 1'b0;
      r_fifoerr  <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_usage    <= w_usage_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_fifoen_q <= FIFOEN;
      r_head     <= w_head_nxt;
      r_empty    <= (w_usage_nxt == L_ZERO);
      r_full     <= w_full_nxt;
      r_trigger  <= w_trigger_nxt;
      r_timeout  <= (w_tmo_nxt == L_TMO_MAX);
      r_oe       <= w_oe_nxt;
      r_fifoerr  <= (w_err_cnt_nxt != L_ZERO);
    end
  end

  assign DOUT    = r_head[7:0];
  assign PE      = r_head[8];
  assign FE      = r_head[9];
  assign BI      = r_head[10];
  assign EMPTY   = r_empty;
  assign FULL    = r_full;
  assign USAGE   = r_usage;
  assign TRIGGER = r_trigger;
  assign TIMEOUT = r_timeout;
  assign OE      = r_oe;
  assign FIFOERR = r_fifoerr;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed scenarios followed by biased random traffic,
// every cycle compared against a queue-based reference of the receive FIFO.

module tb_uart_rx_buffer;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr, fen, we, pe_in, fe_in, bi_in, rd, lsrrd, tick;
  logic [1:0]    rxt;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          pe, fe, bi, empty, full, trigger, timeout, oe, fifoerr;
  logic [AW:0]   usage;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [10:0] m_q[$];
  logic        m_oe;
  int          m_tcnt;
  logic        m_prev_fen;

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .CLEAR(clr), .FIFOEN(fen), .RXTRIG(rxt),
    .WE(we), .DIN(din), .PE_IN(pe_in), .FE_IN(fe_in), .BI_IN(bi_in),
    .RD(rd), .LSRRD(lsrrd), .CHAR_TICK(tick),
    .DOUT(dout), .PE(pe), .FE(fe), .BI(bi), .EMPTY(empty), .FULL(full),
    .USAGE(usage), .TRIGGER(trigger), .TIMEOUT(timeout), .OE(oe), .FIFOERR(fifoerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int level(input logic [1:0] sel);
    case (sel)
      2'b00:   return 1;
      2'b01:   return 16;
      2'b10:   return 32;
      default: return 56;
    endcase
  endfunction

  // Advance the reference by one cycle using the inputs currently driven.
  task automatic model_step();
    bit   flush;
    int   cap;
    bit   was_empty, did_read;
    logic [10:0] e;
    flush     = clr || (fen != m_prev_fen);
    m_prev_fen = fen;
    cap       = fen ? DEPTH : 1;
    was_empty = (m_q.size() == 0);
    e         = {bi_in, fe_in, pe_in, din};
    if (flush || we || rd || was_empty || !fen) m_tcnt = 0;
    else if (tick && m_tcnt < 4) m_tcnt++;
    if (lsrrd) m_oe = 1'b0;
    if (flush) begin
      m_q.delete();
    end else begin
      did_read = rd && (m_q.size() > 0);
      if (we && m_q.size() == cap && !did_read) begin
        m_oe = 1'b1;
        if (!fen) m_q[0] = e;
      end else begin
        if (did_read) void'(m_q.pop_front());
        if (we) m_q.push_back(e);
      end
      if (did_read && !we) begin end
    end
  endtask

  // Compare every DUT output against the reference.
  task automatic check_all();
    int   n, nerr;
    int   cap;
    logic [10:0] h;
    n    = m_q.size();
    cap  = fen ? DEPTH : 1;
    h    = (n != 0) ? m_q[0] : 11'd0;
    nerr = 0;
    foreach (m_q[i]) if (m_q[i][10:8] != 3'b000) nerr++;
    chk("dout",    32'(dout),    32'(h[7:0]));
    chk("pe",      32'(pe),      32'(h[8]));
    chk("fe",      32'(fe),      32'(h[9]));
    chk("bi",      32'(bi),      32'(h[10]));
    chk("empty",   32'(empty),   32'(n == 0));
    chk("full",    32'(full),    32'(n == cap));
    chk("usage",   32'(usage),   32'(n));
    chk("trigger", 32'(trigger), 32'(fen ? (n >= level(rxt)) : (n != 0)));
    chk("timeout", 32'(timeout), 32'(m_tcnt == 4));
    chk("oe",      32'(oe),      32'(m_oe));
    chk("fifoerr", 32'(fifoerr), 32'(nerr != 0));
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit after rising edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic [2:0] flg,
                     input logic r, input logic l, input logic t, input logic c);
    @(negedge clk);
    we = w; din = d; {bi_in, fe_in, pe_in} = flg; rd = r; lsrrd = l; tick = t; clr = c;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [7:0] d, input logic [2:0] flg);
    cyc(1'b1, d, flg, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    cyc(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic oe_before;
    rst = 1'b1; clr = 1'b0; fen = 1'b1; rxt = 2'b00;
    we = 1'b0; din = 8'h00; pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
    rd = 1'b0; lsrrd = 1'b0; tick = 1'b0;
    m_oe = 1'b0; m_tcnt = 0; m_prev_fen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_usage",   32'(usage),   32'd0);
    chk("rst_dout",    32'(dout),    32'd0);
    chk("rst_flags",   32'({full, trigger, timeout, oe, fifoerr, pe, fe, bi}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Basic FWFT ordering
    wr(8'h41, 3'b000);
    chk("fwft_dout",  32'(dout),  32'h41);
    chk("fwft_empty", 32'(empty), 32'd0);
    wr(8'h42, 3'b000);
    wr(8'h43, 3'b000);
    for (int i = 0; i < 3; i++) begin
      chk("fwft_order", 32'(dout), 32'(8'h41 + i));
      rd1();
    end
    chk("drain_usage", 32'(usage), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Fill to capacity, then overrun
    for (int i = 0; i < 64; i++) wr(8'(i), 3'b000);
    wr(8'hFF, 3'b000);
    chk("ovr_full",  32'(full),  32'd1);
    chk("ovr_oe",    32'(oe),    32'd1);
    chk("ovr_usage", 32'(usage), 32'd64);
    for (int i = 0; i < 64; i++) begin
      chk("ovr_data", 32'(dout), 32'(i));
      rd1();
    end
    chk("ovr_dropped_empty", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lsr_clears_oe", 32'(oe), 32'd0);

    // Trigger level 32
    rxt = 2'b10;
    for (int i = 0; i < 31; i++) wr(8'(i + 8'h80), 3'b000);
    chk("trig_31", 32'(trigger), 32'd0);
    wr(8'h9F, 3'b000);
    chk("trig_32", 32'(trigger), 32'd1);
    rd1();
    chk("trig_rd", 32'(trigger), 32'd0);
    cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    rxt = 2'b00;

    // Error flags and FIFOERR
    wr(8'h00, 3'b110);
    wr(8'h55, 3'b000);
    chk("err_fifoerr", 32'(fifoerr), 32'd1);
    chk("err_bi",      32'(bi),      32'd1);
    chk("err_fe",      32'(fe),      32'd1);
    rd1();
    chk("err_cleared", 32'(fifoerr), 32'd0);
    chk("err_next",    32'(dout),    32'h55);
    chk("err_nflags",  32'({pe, fe, bi}), 32'd0);
    rd1();

    // Character timeout and flush
    wr(8'h66, 3'b000);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_pre", 32'(timeout), 32'd0);
      cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("tmo_set", 32'(timeout), 32'd1);
    rd1();
    chk("tmo_rd", 32'(timeout), 32'd0);
    for (int i = 0; i < 5; i++) wr(8'(i), 3'b001);
    oe_before = oe;
    cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_usage", 32'(usage), 32'd0);
    chk("clr_oe",    32'(oe),    32'(oe_before));

    // Holding-register mode
    fen = 1'b0;
    idle();
    wr(8'h11, 3'b000);
    wr(8'h22, 3'b000);
    chk("nf_oe",    32'(oe),    32'd1);
    chk("nf_dout",  32'(dout),  32'h22);
    chk("nf_usage", 32'(usage), 32'd1);
    fen = 1'b1;
    idle();
    chk("nf_flush", 32'(empty), 32'd1);
    chk("nf_oe_kept", 32'(oe), 32'd1);

    // Biased random traffic
    for (int p = 0; p < 30; p++) begin
      int wb, rb;
      wb = (p % 2 == 1) ? 85 : 25;
      rb = (p % 2 == 1) ? 15 : 70;
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(299) == 0) fen = ~fen;
        if ($urandom_range(49) == 0) rxt = 2'($urandom_range(3));
        cyc(($urandom_range(99) < wb), 8'($urandom), (($urandom_range(4) == 0) ? 3'($urandom) : 3'b000),
            ($urandom_range(99) < rb), ($urandom_range(19) == 0), ($urandom_range(2) == 0),
            ($urandom_range(199) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive FIFO that consumes each character produced by the UART receive state machine, together with that character's parity, framing and break flags. It sits between the receiver and the register file, which reads RBR and LSR. It provides 16550/16750 FIFO semantics:
- configurable depth
- non-FIFO (single holding register) mode
- receive trigger level
- character timeout
- overrun detection
- a per-FIFO error summary

Parameters:
DEPTH, 64, entry count; only 16 or 64 are legal. Selects the trigger-level table.
AW, $clog2(DEPTH), pointer width. Derived; must not be overridden.

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
CLEAR  in  1  FIFO flush pulse (FCR receive-reset)
FIFOEN  in  1  1 = FIFO mode, 0 = single holding register
RXTRIG  in  2  trigger-level select (FCR[7:6])
WE  in  1  one-cycle write strobe (receiver "character finished")
DIN  in  8  received character, valid while WE=1
PE_IN  in  1  parity error of the incoming character
FE_IN  in  1  framing error of the incoming character
BI_IN  in  1  break indication of the incoming character
RD  in  1  one-cycle read strobe (RBR read)
LSRRD  in  1  one-cycle LSR-read strobe
CHAR_TICK  in  1  one-cycle pulse per character time, from the baud logic
DOUT  out  8  head-entry data
PE  out  1  head-entry parity error
FE  out  1  head-entry framing error
BI  out  1  head-entry break
EMPTY  out  1  no entries stored
FULL  out  1  usage == capacity
USAGE  out  AW+1  number of stored entries
TRIGGER  out  1  trigger level reached
TIMEOUT  out  1  character timeout pending
OE  out  1  overrun error (sticky)
FIFOERR  out  1  at least one stored entry has PE, FE or BI set

Behaviour:
Reset (RST=1):
- Pointers, USAGE, timeout counter and error counter cleared.
- EMPTY=1; FULL, TRIGGER, TIMEOUT, OE, FIFOERR = 0.
- DOUT=0x00; PE/FE/BI=0.
- Storage contents need no reset.

Storage and first-word-fall-through:
- Each entry is 11 bits: {BI, FE, PE, DATA}.
- DOUT/PE/FE/BI always show the entry at the read pointer, driven from registered state.
- A write into an empty buffer is visible at the head, with EMPTY=0, on the next cycle.
- While EMPTY=1, the head outputs are 0.

Capacity:
- Capacity is DEPTH when FIFOEN=1, and 1 when FIFOEN=0.
- Pointers wrap modulo DEPTH.

Write (WE=1):
- Not full: store the entry and increment USAGE.
- Full and FIFOEN=1: the new character is dropped, the FIFO is unchanged, and OE is set.
- Full and FIFOEN=0: the held entry is overwritten with the new character and OE is set.

Read (RD=1):
- Not empty: advance the read pointer and decrement USAGE.
- Empty: RD is ignored; no underflow.

Simultaneous WE and RD:
- Both honoured; USAGE unchanged.
- When full, the read frees a slot, so the write is accepted and OE is not set.
- When empty, only the write takes effect.

OE:
- Sticky; cleared in the cycle after LSRRD.
- If an overrun occurs in the same cycle as LSRRD, OE stays 1.
- CLEAR does not affect OE.

Error counter:
- Range 0..DEPTH.
- Increments when an accepted write has any error flag set.
- Decrements when a read pops an entry that has any error flag set.
- Simultaneous increment and decrement leaves it unchanged.
- For an FIFOEN=0 overwrite, the count is recomputed as the flag state of the new entry.
- FIFOERR = (count != 0).

Trigger levels (TRIGGER = USAGE >= level when FIFOEN=1; TRIGGER = !EMPTY when FIFOEN=0):
- DEPTH=64: RXTRIG 00/01/10/11 → 1/16/32/56.
- DEPTH=16: RXTRIG 00/01/10/11 → 1/4/8/14.

Timeout:
- A 3-bit counter increments on CHAR_TICK while FIFOEN=1 and EMPTY=0, saturating at 4.
- Cleared by WE, RD, CLEAR, EMPTY=1 or FIFOEN=0.
- TIMEOUT = (counter == 4).
- A clear and a CHAR_TICK in the same cycle leave the counter at 0.

Flush:
- Triggered by CLEAR, or by any change of FIFOEN (FIFOEN is registered and compared with its value from the previous cycle).
- A flush empties pointers, USAGE, the error counter and the timeout counter in the next cycle.
- A WE in the flush cycle is discarded.
- Flush has priority over read and write.

Test Plan:
- Reset, then DEPTH=64, FIFOEN=1: write 0x41, 0x42, 0x43 → EMPTY=0 and DOUT=0x41 one cycle after the first WE. Three RDs return 0x41, 0x42, 0x43; USAGE then 0 and EMPTY=1.
- 64 writes 0x00..0x3F, then WE with DIN=0xFF → FULL=1, OE=1, USAGE=64. Reads return 0x00..0x3F; 0xFF is never seen. LSRRD → OE=0 the next cycle.
- RXTRIG=10: write 31 entries → TRIGGER=0; 32nd → TRIGGER=1; one RD → TRIGGER=0.
- Write 0x00 with BI_IN=1 and FE_IN=1, then 0x55 clean → FIFOERR=1, head BI=1, FE=1. RD → FIFOERR=0, DOUT=0x55, PE/FE/BI=0.
- Write one entry, then four CHAR_TICKs with no access → TIMEOUT=1 after the fourth. RD → TIMEOUT=0. CLEAR with 5 entries stored → EMPTY=1, USAGE=0, OE unchanged.
- FIFOEN=0: write 0x11, then 0x22 without a read → OE=1, DOUT=0x22, USAGE=1. Toggle FIFOEN to 1 → buffer flushed, EMPTY=1.
